rxuart_lite: RTL and testbench

RXUART_LITE -- requirements
Module: rxuart_lite

---
 rtl/rxuart_lite.sv | 205 ++++++++++++++++++++
 tb/tb_rxuart_lite.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rxuart_lite.sv
// rxuart_lite: 8/7/6/5-bit UART receiver with optional parity (RXUART_PARITY_EN), frame/break detect.
// Latency: o_wr fires the clock after the first stop-bit sample; no backpressure, o_data holds until next o_wr.
module rxuart_lite #(
    parameter logic [29:0] INITIAL_SETUP = 30'd868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [29:0] i_setup,
    input  logic        i_uart_rx,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_frame_err,
    output logic        o_parity_err,
    output logic        o_break
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
`ifdef RXUART_PARITY_EN
        PARITY     = 3'd3,
`endif
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t      state, state_d;
    logic        rx_meta, rx_sync;
    logic [29:0] setup_r, setup_d;
    logic [27:0] cnt, cnt_d;
    logic [3:0]  idx, idx_d;
    logic [7:0]  data_r, data_d;
    logic        wr_d, ferr_d, brk_d;
    logic [7:0]  odata_d;
    logic [3:0]  nbits;
    logic        expire;
    logic [27:0] full_load, half_load, rest_load;

    assign nbits     = 4'd8 - {2'b00, setup_r[29:28]};
    assign expire    = (cnt <= 28'd1);
    assign full_load = {4'd0, setup_r[23:0]};
    // The start-edge load uses the live setup word, since setup_r is being captured on the same edge.
    assign half_load = {5'd0, i_setup[23:1]};
    assign rest_load = full_load - {5'd0, setup_r[23:1]};

`ifdef RXUART_PARITY_EN
    logic par_en, par_exp, perr_r, perr_d, operr_d;
    assign par_en  = setup_r[26];
    assign par_exp = setup_r[25] ? setup_r[24] : (^data_r ^ setup_r[24]);
`else
    logic unused_setup;
    assign unused_setup = ^setup_r[26:24];
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:       if (!rx_sync) state_d = START;
            START:      if (expire) state_d = rx_sync ? IDLE : DATA;
            DATA: begin
                if (expire && (idx == nbits - 4'd1)) begin
`ifdef RXUART_PARITY_EN
                    state_d = par_en ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef RXUART_PARITY_EN
            PARITY:     if (expire) state_d = STOP;
`endif
            STOP:       if (expire) state_d = rx_sync ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rx_sync) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        setup_d = setup_r;
        cnt_d   = (cnt != 28'd0) ? cnt - 28'd1 : 28'd0;
        idx_d   = idx;
        data_d  = data_r;
        wr_d    = 1'b0;
        odata_d = o_data;
        ferr_d  = o_frame_err;
        brk_d   = o_break;
`ifdef RXUART_PARITY_EN
        perr_d  = perr_r;
        operr_d = o_parity_err;
`endif
        case (state)
            IDLE: begin
                setup_d = i_setup;
                brk_d   = 1'b0;
                if (!rx_sync) begin
                    cnt_d  = half_load;
                    idx_d  = 4'd0;
                    data_d = 8'h00;
`ifdef RXUART_PARITY_EN
                    perr_d = 1'b0;
`endif
                end
            end
            START: if (expire) cnt_d = full_load;
            DATA: begin
                if (expire) begin
                    cnt_d  = full_load;
                    data_d = {rx_sync, data_r[7:1]};
                    idx_d  = idx + 4'd1;
                end
            end
`ifdef RXUART_PARITY_EN
            PARITY: begin
                if (expire) begin
                    cnt_d  = full_load;
                    perr_d = (rx_sync != par_exp);
                    idx_d  = idx + 4'd1;
                end
            end
`endif
            STOP: begin
                if (expire) begin
                    wr_d    = 1'b1;
                    odata_d = data_r >> setup_r[29:28];
                    ferr_d  = !rx_sync;
`ifdef RXUART_PARITY_EN
                    operr_d = perr_r;
`endif
                    // idx now counts whole baud periods since the start edge, for break timing.
                    if (!rx_sync) begin
                        cnt_d = rest_load;
                        idx_d = idx + 4'd1;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rx_sync) begin
                    brk_d = 1'b0;
                end else if (expire && !o_break) begin
                    if (idx == 4'd15) begin
                        brk_d = 1'b1;
                    end else begin
                        idx_d = idx + 4'd1;
                        cnt_d = full_load;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            setup_r     <= INITIAL_SETUP;
            cnt         <= 28'd0;
            idx         <= 4'd0;
            data_r      <= 8'h00;
            o_wr        <= 1'b0;
            o_data      <= 8'h00;
            o_frame_err <= 1'b0;
            o_break     <= 1'b0;
        end else begin
            setup_r     <= setup_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            data_r      <= data_d;
            o_wr        <= wr_d;
            o_data      <= odata_d;
            o_frame_err <= ferr_d;
            o_break     <= brk_d;
        end
    end

`ifdef RXUART_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perr_r       <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            perr_r       <= perr_d;
            o_parity_err <= operr_d;
        end
    end
`endif

endmodule

// File: tb/tb_rxuart_lite.sv
`timescale 1ns/1ps
// Directed bench for rxuart_lite at 16 clocks per baud.
module tb_rxuart_lite;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [29:0] i_setup;
    logic        i_uart_rx;
    logic        o_wr;
    logic [7:0]  o_data;
    logic        o_frame_err;
    logic        o_parity_err;
    logic        o_break;

    rxuart_lite dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_setup      (i_setup),
        .i_uart_rx    (i_uart_rx),
        .o_wr         (o_wr),
        .o_data       (o_data),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_break      (o_break)
    );

    localparam logic [29:0] SETUP_8N1 = 30'd16;
    localparam logic [29:0] SETUP_PAR = {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 24'd16};
    localparam logic [29:0] SETUP_7N1 = {2'b01, 4'b0000, 24'd16};

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Capture every o_wr strobe away from the active edge.
    int         wr_cnt = 0;
    int         wr_cyc = 0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ferr = 1'b0;
    logic       wr_perr = 1'b0;
    always @(negedge i_clk) begin
        if (o_wr === 1'b1) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc;
            wr_data = o_data;
            wr_ferr = o_frame_err;
            wr_perr = o_parity_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        @(negedge i_clk);
        while (cyc < t) @(negedge i_clk);
    endtask

    task automatic drive_bit(input logic v);
        i_uart_rx = v;
        wait_clk(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                              input logic stop, output int e0);
        e0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (par >= 0) drive_bit(par[0]);
        drive_bit(stop);
        i_uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        i_reset   = 1'b1;
        i_uart_rx = 1'b1;
        i_setup   = SETUP_8N1;
        wait_clk(4);
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_wr, o_data, o_frame_err, o_parity_err, o_break} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {o_wr, o_data, o_frame_err, o_parity_err, o_break});
        end
        wait_clk(4);
    endtask

    task automatic test_8n1();
        int n0, e0;
        n0 = wr_cnt;
        send_frame(8'h55, 8, -1, 1'b1, e0);
        wait_clk(20);
        checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL 8n1_wr_count: got %0d expected 1", wr_cnt - n0); end
        checks++; if (wr_data !== 8'h55) begin errors++; $display("FAIL 8n1_data: got %h expected 55", wr_data); end
        checks++; if ({wr_ferr, wr_perr} !== 2'b00) begin errors++; $display("FAIL 8n1_flags: got %b expected 00", {wr_ferr, wr_perr}); end
        // 2 sync flops + detect edge + 8 half-baud + 9 full bauds
        checks++; if (wr_cyc - e0 !== 155) begin errors++; $display("FAIL 8n1_latency: got %0d expected 155", wr_cyc - e0); end
        checks++; if (o_data !== 8'h55 || o_wr !== 1'b0) begin errors++; $display("FAIL 8n1_hold: got data %h wr %b expected 55 0", o_data, o_wr); end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = wr_cnt;
        i_uart_rx = 1'b0;
        wait_clk(4);
        i_uart_rx = 1'b1;
        wait_clk(40);
        checks++; if (wr_cnt !== n0) begin errors++; $display("FAIL glitch_no_wr: got %0d strobes expected 0", wr_cnt - n0); end
        checks++; if (o_break !== 1'b0) begin errors++; $display("FAIL glitch_break: got %b expected 0", o_break); end
    endtask

    task automatic test_parity();
        int n0, e0;
        logic exp_ferr2, exp_perr2;
        int exp_lat;
`ifdef RXUART_PARITY_EN
        exp_ferr2 = 1'b0; exp_perr2 = 1'b1; exp_lat = 171;
`else
        exp_ferr2 = 1'b1; exp_perr2 = 1'b0; exp_lat = 155;
`endif
        i_setup = SETUP_PAR;
        wait_clk(2);
        n0 = wr_cnt;
        send_frame(8'hA5, 8, 1, 1'b1, e0);
        wait_clk(20);
        checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL par_ok_count: got %0d expected 1", wr_cnt - n0); end
        checks++; if (wr_data !== 8'hA5) begin errors++; $display("FAIL par_ok_data: got %h expected a5", wr_data); end
        checks++; if ({wr_ferr, wr_perr} !== 2'b00) begin errors++; $display("FAIL par_ok_flags: got %b expected 00", {wr_ferr, wr_perr}); end
        checks++; if (wr_cyc - e0 !== exp_lat) begin errors++; $display("FAIL par_latency: got %0d expected %0d", wr_cyc - e0, exp_lat); end
        n0 = wr_cnt;
        send_frame(8'hA5, 8, 0, 1'b1, e0);
        wait_clk(20);
        checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", wr_cnt - n0); end
        checks++; if (wr_data !== 8'hA5) begin errors++; $display("FAIL par_bad_data: got %h expected a5", wr_data); end
        checks++; if ({wr_ferr, wr_perr} !== {exp_ferr2, exp_perr2}) begin errors++; $display("FAIL par_bad_flags: got %b expected %b", {wr_ferr, wr_perr}, {exp_ferr2, exp_perr2}); end
        i_setup = SETUP_8N1;
        wait_clk(2);
    endtask

    task automatic test_7bit();
        int n0, e0;
        i_setup = SETUP_7N1;
        wait_clk(2);
        n0 = wr_cnt;
        send_frame(8'h41, 7, -1, 1'b1, e0);
        wait_clk(20);
        checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL b7_count: got %0d expected 1", wr_cnt - n0); end
        checks++; if ({wr_data, wr_ferr} !== {8'h41, 1'b0}) begin errors++; $display("FAIL b7_ok: got %h/%b expected 41/0", wr_data, wr_ferr); end
        checks++; if (wr_cyc - e0 !== 139) begin errors++; $display("FAIL b7_latency: got %0d expected 139", wr_cyc - e0); end
        n0 = wr_cnt;
        send_frame(8'h41, 7, -1, 1'b0, e0);
        wait_clk(20);
        checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL b7_ferr_count: got %0d expected 1", wr_cnt - n0); end
        checks++; if ({wr_data, wr_ferr} !== {8'h41, 1'b1}) begin errors++; $display("FAIL b7_ferr: got %h/%b expected 41/1", wr_data, wr_ferr); end
        i_setup = SETUP_8N1;
        wait_clk(2);
    endtask

    task automatic test_break();
        int n0, e0;
        n0 = wr_cnt;
        i_uart_rx = 1'b0;
        e0 = cyc;
        // 16 bauds from the detected start edge, which trails the line edge by 3 clocks
        wait_cyc(e0 + 258);
        checks++; if (o_break !== 1'b0) begin errors++; $display("FAIL break_early: got %b expected 0", o_break); end
        wait_cyc(e0 + 259);
        checks++; if (o_break !== 1'b1) begin errors++; $display("FAIL break_assert: got %b expected 1", o_break); end
        repeat (320 - 259) @(posedge i_clk);
        #1;
        i_uart_rx = 1'b1;
        wait_cyc(e0 + 322);
        checks++; if (o_break !== 1'b1) begin errors++; $display("FAIL break_hold: got %b expected 1", o_break); end
        wait_cyc(e0 + 323);
        checks++; if (o_break !== 1'b0) begin errors++; $display("FAIL break_release: got %b expected 0", o_break); end
        checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL break_wr_count: got %0d expected 1", wr_cnt - n0); end
        checks++; if ({wr_data, wr_ferr} !== {8'h00, 1'b1}) begin errors++; $display("FAIL break_word: got %h/%b expected 00/1", wr_data, wr_ferr); end
        wait_clk(20);
    endtask

    task automatic test_back_to_back();
        int n0, e0, e1;
        n0 = wr_cnt;
        send_frame(8'h12, 8, -1, 1'b1, e0);
        checks++; if (wr_data !== 8'h12) begin errors++; $display("FAIL b2b_first: got %h expected 12", wr_data); end
        send_frame(8'hEF, 8, -1, 1'b1, e1);
        wait_clk(20);
        checks++; if (wr_data !== 8'hEF) begin errors++; $display("FAIL b2b_second: got %h expected ef", wr_data); end
        checks++; if (wr_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", wr_cnt - n0); end
        checks++; if (wr_cyc - e1 !== 155) begin errors++; $display("FAIL b2b_latency: got %0d expected 155", wr_cyc - e1); end
    endtask

    task automatic test_reset_mid_frame();
        int n0, e0;
        n0 = wr_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        i_uart_rx = 1'b1;
        wait_clk(8);
        i_reset = 1'b1;
        wait_clk(3);
        i_reset = 1'b0;
        wait_clk(200);
        checks++; if (wr_cnt !== n0) begin errors++; $display("FAIL midrst_no_wr: got %0d strobes expected 0", wr_cnt - n0); end
        checks++; if ({o_wr, o_data, o_frame_err, o_parity_err, o_break} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 000", {o_wr, o_data, o_frame_err, o_parity_err, o_break});
        end
        send_frame(8'h3C, 8, -1, 1'b1, e0);
        wait_clk(20);
        checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", wr_cnt - n0); end
        checks++; if ({wr_data, wr_ferr} !== {8'h3C, 1'b0}) begin errors++; $display("FAIL midrst_next_word: got %h/%b expected 3c/0", wr_data, wr_ferr); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_glitch();
        test_parity();
        test_7bit();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
